// File: rtl/mul_sign_acc_pkg.sv
// Shared defaults and configuration rule for the signed product accumulator.
package mul_sign_acc_pkg;

    localparam int DW_DEF    = 8;
    localparam int KLEN_DEF  = 25;
    localparam int ACC_W_DEF = 24;

    // Accumulator must hold KLEN full-scale products plus a sign bit without wrapping.
    function automatic bit acc_w_ok(input int dw, input int klen, input int acc_w);
        return (acc_w >= 2 * dw + $clog2(klen) + 1) && (klen >= 2) && (klen <= 256);
    endfunction

    localparam bit ACC_W_DEF_OK = acc_w_ok(DW_DEF, KLEN_DEF, ACC_W_DEF);

endpackage

// File: rtl/mul_sign_acc_mag.sv
// Restores two's complement from an unsigned product magnitude and a sign flag.
// Latency: combinational. Backpressure: none.
module mag_to_twos #(
    parameter int DW    = 8,
    parameter int ACC_W = 24
) (
    input  logic [2*DW-1:0]         mag,
    input  logic                    sign,
    output logic signed [ACC_W-1:0] term
);

    logic signed [ACC_W-1:0] zext;

    always_comb begin
        zext = '0;
        zext[2*DW-1:0] = mag;
        term = sign ? -zext : zext;
    end

endmodule

// File: rtl/mul_sign_acc.sv
// Sign-restores PE products and sums KLEN of them into one signed result.
// Latency: final term at edge t -> out_valid in cycle t+1.
// Backpressure: one-entry output register; a sum completing into a full, unready register is dropped and sets sticky ovf.
module mul_sign_acc
    import mul_sign_acc_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int KLEN  = KLEN_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*DW-1:0]           mul_result,
    input  logic                      result_flag,
    input  logic                      signal_flag,
    input  logic                      flush,
    output logic signed [ACC_W-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(KLEN)-1:0]   term_cnt,
    output logic                      ovf
);

    localparam int CW = $clog2(KLEN);
    localparam logic [CW-1:0] LAST = CW'(KLEN - 1);

    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic                    take;
    logic                    done;

    mag_to_twos #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mag_to_twos (
        .mag  (mul_result),
        .sign (signal_flag),
        .term (term)
    );

    always_comb begin
        take = result_flag && !flush;
        done = take && (term_cnt == LAST);
        sum  = ((term_cnt == '0) ? '0 : acc) + term;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            term_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (flush || done) begin
                acc      <= '0;
                term_cnt <= '0;
            end else if (take) begin
                acc      <= sum;
                term_cnt <= term_cnt + CW'(1);
            end

            // Accept-and-reload in the same cycle keeps the register streaming without loss.
            if (done) begin
                if (!out_valid || out_ready) begin
                    out_data  <= sum;
                    out_valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_sign_acc.sv
// Directed and random checks of mul_sign_acc at KLEN=4 and KLEN=25 against a sum-of-terms model.
module tb_mul_sign_acc;

    logic               clk = 1'b0;
    logic               rst;
    logic [15:0]        mul_result;
    logic               result_flag;
    logic               signal_flag;
    logic               flush;
    logic               out_ready;

    logic signed [23:0] a_out_data, b_out_data;
    logic               a_out_valid, b_out_valid;
    logic [1:0]         a_term_cnt;
    logic [4:0]         b_term_cnt;
    logic               a_ovf, b_ovf;

    int nassert = 0;
    int nfail   = 0;

    // Reference state per instance: index 0 is KLEN=4, index 1 is KLEN=25.
    int   psum[2];
    int   pcnt[2];
    int   odata[2];
    logic ovalid[2];
    logic ovf_m[2];

    always #5 clk = ~clk;

    mul_sign_acc #(.DW(8), .KLEN(4), .ACC_W(24)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .mul_result  (mul_result),
        .result_flag (result_flag),
        .signal_flag (signal_flag),
        .flush       (flush),
        .out_data    (a_out_data),
        .out_valid   (a_out_valid),
        .out_ready   (out_ready),
        .term_cnt    (a_term_cnt),
        .ovf         (a_ovf)
    );

    mul_sign_acc #(.DW(8), .KLEN(25), .ACC_W(24)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .mul_result  (mul_result),
        .result_flag (result_flag),
        .signal_flag (signal_flag),
        .flush       (flush),
        .out_data    (b_out_data),
        .out_valid   (b_out_valid),
        .out_ready   (out_ready),
        .term_cnt    (b_term_cnt),
        .ovf         (b_ovf)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        nassert++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic v, input int mag, input logic s,
                              input logic fl, input logic rdy, input logic r);
        for (int i = 0; i < 2; i++) begin
            int  k;
            int  t;
            int  sm;
            bit  done;
            k    = (i == 0) ? 4 : 25;
            t    = s ? -mag : mag;
            sm   = 0;
            done = 0;
            if (r) begin
                psum[i] = 0; pcnt[i] = 0; odata[i] = 0; ovalid[i] = 0; ovf_m[i] = 0;
            end else begin
                if (fl) begin
                    psum[i] = 0; pcnt[i] = 0;
                end else if (v) begin
                    psum[i] += t;
                    pcnt[i]++;
                    if (pcnt[i] == k) begin
                        sm = psum[i]; psum[i] = 0; pcnt[i] = 0; done = 1;
                    end
                end
                if (done) begin
                    if (!ovalid[i] || rdy) begin
                        odata[i] = sm; ovalid[i] = 1;
                    end else begin
                        ovf_m[i] = 1;
                    end
                end else if (ovalid[i] && rdy) begin
                    ovalid[i] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic v, input int mag, input logic s,
                        input logic fl, input logic rdy, input logic r);
        rst         = r;
        result_flag = v;
        mul_result  = mag[15:0];
        signal_flag = s;
        flush       = fl;
        out_ready   = rdy;
        @(posedge clk);
        model_edge(v, mag, s, fl, rdy, r);
        #1;
        chk("a_out_valid", a_out_valid, ovalid[0]);
        chk("a_out_data",  a_out_data,  odata[0]);
        chk("a_ovf",       a_ovf,       ovf_m[0]);
        chk("a_term_cnt",  a_term_cnt,  pcnt[0]);
        chk("b_out_valid", b_out_valid, ovalid[1]);
        chk("b_out_data",  b_out_data,  odata[1]);
        chk("b_ovf",       b_ovf,       ovf_m[1]);
        chk("b_term_cnt",  b_term_cnt,  pcnt[1]);
    endtask

    initial begin
        // Reset state
        step(0, 0, 0, 0, 0, 1);
        chk("rst_a_data",  a_out_data, 0);
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_cnt",   a_term_cnt, 0);
        chk("rst_a_ovf",   a_ovf, 0);

        // Basic window: 10 - 20 + 30 + 40 = 60
        step(1, 10, 0, 0, 1, 0);
        step(1, 20, 1, 0, 1, 0);
        step(1, 30, 0, 0, 1, 0);
        chk("basic_pre_valid", a_out_valid, 0);
        step(1, 40, 0, 0, 1, 0);
        chk("basic_valid", a_out_valid, 1);
        chk("basic_data",  a_out_data, 60);
        step(0, 0, 0, 0, 1, 0);
        chk("basic_valid_one_cycle", a_out_valid, 0);

        // Gap inside a window
        step(1, 10, 0, 0, 1, 0);
        step(1, 20, 1, 0, 1, 0);
        step(0, 99, 1, 0, 1, 0);
        chk("gap_cnt_hold1", a_term_cnt, 2);
        step(0, 99, 0, 0, 1, 0);
        chk("gap_cnt_hold2", a_term_cnt, 2);
        step(1, 30, 0, 0, 1, 0);
        step(1, 40, 0, 0, 1, 0);
        chk("gap_data", a_out_data, 60);

        // Full-scale negative window at KLEN=25
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 25; i++) step(1, 65025, 1, 0, 1, 0);
        chk("full_scale_valid", b_out_valid, 1);
        chk("full_scale_data",  b_out_data, -1625625);

        // Back-to-back windows, consumer stalled: second sum dropped
        step(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) step(1, i, 0, 0, 0, 0);
        chk("drop_ovf",  a_ovf, 1);
        chk("drop_data", a_out_data, 10);

        // Same, but consumer accepts on the second completion
        step(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) step(1, i, 0, 0, (i == 8), 0);
        chk("reload_ovf",  a_ovf, 0);
        chk("reload_data", a_out_data, 26);

        // Flush with a valid term, then a clean window of 5s
        step(0, 0, 0, 0, 0, 1);
        step(1, 7, 0, 0, 0, 0);
        step(1, 9, 1, 0, 0, 0);
        step(1, 100, 0, 1, 0, 0);
        chk("flush_cnt", a_term_cnt, 0);
        for (int i = 0; i < 4; i++) step(1, 5, 0, 0, 0, 0);
        chk("flush_data", a_out_data, 20);

        // Reset mid-window with a pending output
        step(1, 3, 0, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0);
        step(1, 6, 1, 0, 0, 1);
        chk("midrst_data",  a_out_data, 0);
        chk("midrst_valid", a_out_valid, 0);
        chk("midrst_cnt",   a_term_cnt, 0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            int m;
            m = ($urandom_range(0, 7) == 0) ? 65535 : int'($urandom_range(0, 65535));
            step($urandom_range(0, 3) != 0, m, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 149) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
